// File: rtl/lenet_tops.sv
// LeNet top-level sequencer: steps five layer engines, picks the argmax class and drives the 7-seg/LED status.
// Optional per-layer watchdog with ERR state when TOPS_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a start edge
// C1..F5 | layer engine running, waiting for its done pulse
// ARGMAX | scanning the ten registered scores, one per cycle
// DONE   | class_id valid, held until reset
// ERR    | layer watchdog expired (TOPS_TIMEOUT_EN only), held until reset
module lenet_tops #(
    parameter int SCAN_DIV = 50000,
    parameter int TIMEOUT  = 2000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [4:0]  graph,
    output logic [4:0]  img_sel,
    output logic [4:0]  layer_start,
    input  logic [4:0]  layer_done,
    input  logic [79:0] result,
    output logic        c1_finish,
    output logic        c2_finish,
    output logic        c3_finish,
    output logic        f4_finish,
    output logic        f5_finish,
    output logic        lenet_finish,
    output logic [3:0]  class_id,
    output logic [7:0]  an,
    output logic [7:0]  a_to_g,
    output logic [2:0]  led_rgb
);

    typedef enum logic [3:0] {
        S_IDLE, S_C1, S_C2, S_C3, S_F4, S_F5, S_ARGMAX, S_DONE
`ifdef TOPS_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t             state, state_nxt;
    logic               start_q;
    logic               run_go;
    logic [4:0]         pulse_nxt;
    logic [4:0]         layer_bit;
    logic               layer_hit;
    logic [4:0]         finish;
    logic               has_run;
    logic [79:0]        result_q;
    logic [3:0]         scan_idx;
    logic signed [7:0]  best;
    logic signed [7:0]  cur;
    logic [3:0]         best_idx;
    logic               take;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit;
    logic [3:0]         tens, units;
    logic [7:0]         seg;

`ifdef TOPS_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [TMR_W-1:0]   tmr;

    // Down-counter reloads on every state change, so each layer gets a fresh budget.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmr <= TMR_W'(TIMEOUT - 1);
        end else if (state_nxt != state) begin
            tmr <= TMR_W'(TIMEOUT - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end
`endif

    assign run_go = (state == S_IDLE) && start && !start_q;

    always_comb begin
        state_nxt = state;
        pulse_nxt = '0;
        layer_bit = '0;
        layer_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_go) begin
                    state_nxt = S_C1;
                    pulse_nxt = 5'b00001;
                end
            end
            S_C1, S_C2, S_C3, S_F4, S_F5: begin
                layer_bit = 5'b00001 << (state - S_C1);
                layer_hit = |(layer_done & layer_bit);
                if (layer_hit) begin
                    state_nxt = state_t'(state + 4'd1);
                    pulse_nxt = (state == S_F5) ? 5'b00000 : (layer_bit << 1);
                end
`ifdef TOPS_TIMEOUT_EN
                else if (tmr == '0) begin
                    state_nxt = S_ERR;
                end
`endif
            end
            S_ARGMAX: begin
                if (scan_idx == 4'd9) state_nxt = S_DONE;
            end
            default: ;
        endcase
    end

    // Scores shift down one byte per ARGMAX cycle; strict compare keeps the lower index on ties.
    assign cur  = result_q[7:0];
    assign take = (scan_idx == 4'd0) || (cur > best);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            layer_start <= '0;
            finish      <= '0;
            class_id    <= '0;
            img_sel     <= '0;
            has_run     <= 1'b0;
            result_q    <= '0;
            scan_idx    <= '0;
            best        <= '0;
            best_idx    <= '0;
        end else begin
            state       <= state_nxt;
            start_q     <= start;
            layer_start <= pulse_nxt;
            if (run_go) begin
                img_sel  <= graph;
                finish   <= '0;
                class_id <= '0;
                has_run  <= 1'b1;
            end
            if (layer_hit) finish <= finish | layer_bit;
            if (state == S_F5 && layer_hit) begin
                result_q <= result;
                scan_idx <= '0;
            end
            if (state == S_ARGMAX) begin
                result_q <= {8'h00, result_q[79:8]};
                scan_idx <= scan_idx + 4'd1;
                if (take) begin
                    best     <= cur;
                    best_idx <= scan_idx;
                end
                if (scan_idx == 4'd9) class_id <= take ? scan_idx : best_idx;
            end
        end
    end

    assign {f5_finish, f4_finish, c3_finish, c2_finish, c1_finish} = finish;
    assign lenet_finish = (state == S_DONE);

    always_comb begin
        case (state)
            S_IDLE:  led_rgb = 3'b000;
            S_DONE:  led_rgb = 3'b010;
`ifdef TOPS_TIMEOUT_EN
            S_ERR:   led_rgb = 3'b100;
`endif
            default: led_rgb = 3'b001;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    always_comb begin
        if (img_sel >= 5'd30) begin
            tens  = 4'd3;
            units = 4'(img_sel - 5'd30);
        end else if (img_sel >= 5'd20) begin
            tens  = 4'd2;
            units = 4'(img_sel - 5'd20);
        end else if (img_sel >= 5'd10) begin
            tens  = 4'd1;
            units = 4'(img_sel - 5'd10);
        end else begin
            tens  = 4'd0;
            units = img_sel[3:0];
        end
    end

    always_comb begin
        seg = 8'hFF;
        case (digit)
            3'd0: begin
                if (state == S_DONE) seg = hex7(class_id);
`ifdef TOPS_TIMEOUT_EN
                else if (state == S_ERR) seg = 8'h86;
`endif
            end
            3'd6: if (has_run) seg = hex7(units);
            3'd7: if (has_run) seg = hex7(tens);
            default: ;
        endcase
    end

    assign an     = ~(8'b0000_0001 << digit);
    assign a_to_g = seg;

endmodule

// File: tb/tb_lenet_tops.sv
// Directed bench for lenet_tops: run sequencing, argmax, reset behaviour and display scan (SCAN_DIV=4).
module tb_lenet_tops;

    logic        sys_clk = 1'b0;
    logic        sys_rst, start;
    logic [4:0]  graph, img_sel, layer_start, layer_done;
    logic [79:0] result;
    logic        c1_finish, c2_finish, c3_finish, f4_finish, f5_finish, lenet_finish;
    logic [3:0]  class_id;
    logic [7:0]  an, a_to_g;
    logic [2:0]  led_rgb;
    logic [4:0]  fin;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [79:0] RES_PEAK4 = {8'h02, 8'h01, 8'h00, 8'h9C, 8'h31, 8'h32, 8'h07, 8'h14, 8'hFD, 8'h0A};
    localparam logic [79:0] RES_EQ    = {10{8'h05}};
    localparam logic [79:0] RES_NEG9  = {8'h7F, {9{8'h80}}};
    localparam logic [79:0] RES_TIE27 = {8'hF0, 8'hF0, 8'h10, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h10, 8'hF0, 8'hF0};

    assign fin = {f5_finish, f4_finish, c3_finish, c2_finish, c1_finish};

    lenet_tops #(.SCAN_DIV(4), .TIMEOUT(100)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .graph(graph), .img_sel(img_sel),
        .layer_start(layer_start), .layer_done(layer_done), .result(result),
        .c1_finish(c1_finish), .c2_finish(c2_finish), .c3_finish(c3_finish),
        .f4_finish(f4_finish), .f5_finish(f5_finish), .lenet_finish(lenet_finish),
        .class_id(class_id), .an(an), .a_to_g(a_to_g), .led_rgb(led_rgb)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_an(input logic [7:0] v);
        int n = 0;
        while (an !== v && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; start = 1'b0; layer_done = '0;
        tick(); tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic run_layer(input int k, input int dly, input logic [79:0] res, input bit disturb);
        logic [4:0] bit_k = 5'(1 << k);
        n_checks++; if (layer_start !== bit_k) begin n_fail++; $display("FAIL layer_start_%0d: got %b want %b", k, layer_start, bit_k); end
        for (int i = 0; i < dly; i++) begin
            tick();
            if (disturb && k == 3 && i == 0) begin
                layer_done = 5'b00100; start = 1'b1;
                tick();
                layer_done = '0;
                n_checks++; if (fin[3] !== 1'b0) begin n_fail++; $display("FAIL stray_done_f4: got %b want 0", fin[3]); end
                n_checks++; if (led_rgb !== 3'b001) begin n_fail++; $display("FAIL stray_led: got %b want 001", led_rgb); end
                n_checks++; if (layer_start !== 5'b0) begin n_fail++; $display("FAIL stray_start: got %b want 00000", layer_start); end
                start = 1'b0;
            end else begin
                n_checks++; if (layer_start !== 5'b0) begin n_fail++; $display("FAIL pulse_width_%0d: got %b want 00000", k, layer_start); end
            end
        end
        if (k == 4) result = res;
        layer_done = bit_k;
        tick();
        layer_done = '0;
        result = ~res;
        n_checks++; if (fin !== 5'((1 << (k + 1)) - 1)) begin n_fail++; $display("FAIL finish_%0d: got %b want %b", k, fin, 5'((1 << (k + 1)) - 1)); end
        if (k < 4) begin
            n_checks++; if (layer_start !== 5'(1 << (k + 1))) begin n_fail++; $display("FAIL next_start_%0d: got %b want %b", k, layer_start, 5'(1 << (k + 1))); end
        end
    endtask

    task automatic run_layers(input logic [79:0] res, input logic [3:0] cls, input int dly0, input bit disturb);
        for (int k = 0; k < 5; k++) run_layer(k, (k == 0) ? dly0 : 5, res, disturb);
        repeat (9) tick();
        n_checks++; if (lenet_finish !== 1'b0) begin n_fail++; $display("FAIL argmax_early: got %b want 0", lenet_finish); end
        tick();
        n_checks++; if (lenet_finish !== 1'b1) begin n_fail++; $display("FAIL lenet_finish: got %b want 1", lenet_finish); end
        n_checks++; if (class_id !== cls) begin n_fail++; $display("FAIL class_id: got %0d want %0d", class_id, cls); end
        n_checks++; if (led_rgb !== 3'b010) begin n_fail++; $display("FAIL led_done: got %b want 010", led_rgb); end
    endtask

    task automatic do_run(input logic [4:0] g, input logic [79:0] res, input logic [3:0] cls, input int dly0, input bit disturb);
        graph = g; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (img_sel !== g) begin n_fail++; $display("FAIL img_sel_latch: got %0d want %0d", img_sel, g); end
        run_layers(res, cls, dly0, disturb);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; start = 1'b1; graph = 5'd4; layer_done = '0; result = '0;
        tick(); tick();
        n_checks++; if (layer_start !== 5'b0) begin n_fail++; $display("FAIL rst_layer_start: got %b want 0", layer_start); end
        n_checks++; if (fin !== 5'b0) begin n_fail++; $display("FAIL rst_finish: got %b want 0", fin); end
        n_checks++; if (lenet_finish !== 1'b0) begin n_fail++; $display("FAIL rst_lenet_finish: got %b want 0", lenet_finish); end
        n_checks++; if (class_id !== 4'd0) begin n_fail++; $display("FAIL rst_class_id: got %0d want 0", class_id); end
        n_checks++; if (img_sel !== 5'd0) begin n_fail++; $display("FAIL rst_img_sel: got %0d want 0", img_sel); end
        n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL rst_an: got %h want fe", an); end
        n_checks++; if (a_to_g !== 8'hFF) begin n_fail++; $display("FAIL rst_a_to_g: got %h want ff", a_to_g); end
        n_checks++; if (led_rgb !== 3'b000) begin n_fail++; $display("FAIL rst_led: got %b want 000", led_rgb); end
    endtask

    task automatic test_full_run();
        sys_rst = 1'b0;
        tick();
        n_checks++; if (img_sel !== 5'd4) begin n_fail++; $display("FAIL held_start_img_sel: got %0d want 4", img_sel); end
        n_checks++; if (led_rgb !== 3'b001) begin n_fail++; $display("FAIL led_busy: got %b want 001", led_rgb); end
        start = 1'b0;
        run_layers(RES_PEAK4, 4'd4, 5, 1'b0);
        wait_an(8'h7F);
        n_checks++; if (an !== 8'h7F || a_to_g !== 8'hC0) begin n_fail++; $display("FAIL dig7_run1: got an %h seg %h want 7f c0", an, a_to_g); end
        wait_an(8'hBF);
        n_checks++; if (an !== 8'hBF || a_to_g !== 8'h99) begin n_fail++; $display("FAIL dig6_run1: got an %h seg %h want bf 99", an, a_to_g); end
        wait_an(8'hFE);
        n_checks++; if (an !== 8'hFE || a_to_g !== 8'h99) begin n_fail++; $display("FAIL dig0_run1: got an %h seg %h want fe 99", an, a_to_g); end
        wait_an(8'hF7);
        n_checks++; if (an !== 8'hF7 || a_to_g !== 8'hFF) begin n_fail++; $display("FAIL dig3_blank: got an %h seg %h want f7 ff", an, a_to_g); end
    endtask

    task automatic test_done_ignore();
        graph = 5'd20; start = 1'b1;
        tick();
        n_checks++; if (layer_start !== 5'b0) begin n_fail++; $display("FAIL done_restart: got %b want 00000", layer_start); end
        start = 1'b0;
        tick(); tick();
        n_checks++; if (lenet_finish !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %b want 1", lenet_finish); end
        n_checks++; if (img_sel !== 5'd4) begin n_fail++; $display("FAIL done_img_sel: got %0d want 4", img_sel); end
        n_checks++; if (class_id !== 4'd4) begin n_fail++; $display("FAIL done_class: got %0d want 4", class_id); end
    endtask

    task automatic test_ties();
        do_reset();
        do_run(5'd17, RES_EQ, 4'd0, 5, 1'b0);
        wait_an(8'h7F);
        n_checks++; if (an !== 8'h7F || a_to_g !== 8'hF9) begin n_fail++; $display("FAIL dig7_17: got an %h seg %h want 7f f9", an, a_to_g); end
        wait_an(8'hBF);
        n_checks++; if (an !== 8'hBF || a_to_g !== 8'hF8) begin n_fail++; $display("FAIL dig6_17: got an %h seg %h want bf f8", an, a_to_g); end
        wait_an(8'hFE);
        n_checks++; if (an !== 8'hFE || a_to_g !== 8'hC0) begin n_fail++; $display("FAIL dig0_class0: got an %h seg %h want fe c0", an, a_to_g); end
    endtask

    task automatic test_signed();
        do_reset();
        do_run(5'd31, RES_NEG9, 4'd9, 1, 1'b0);
        wait_an(8'h7F);
        n_checks++; if (an !== 8'h7F || a_to_g !== 8'hB0) begin n_fail++; $display("FAIL dig7_31: got an %h seg %h want 7f b0", an, a_to_g); end
        wait_an(8'hBF);
        n_checks++; if (an !== 8'hBF || a_to_g !== 8'hF9) begin n_fail++; $display("FAIL dig6_31: got an %h seg %h want bf f9", an, a_to_g); end
        wait_an(8'hFE);
        n_checks++; if (an !== 8'hFE || a_to_g !== 8'h90) begin n_fail++; $display("FAIL dig0_class9: got an %h seg %h want fe 90", an, a_to_g); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        graph = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        run_layer(0, 5, RES_EQ, 1'b0);
        run_layer(1, 5, RES_EQ, 1'b0);
        tick(); tick();
        sys_rst = 1'b1; layer_done = 5'b00100;
        tick();
        layer_done = '0;
        n_checks++; if (fin !== 5'b0) begin n_fail++; $display("FAIL mid_rst_finish: got %b want 00000", fin); end
        n_checks++; if (layer_start !== 5'b0) begin n_fail++; $display("FAIL mid_rst_start: got %b want 00000", layer_start); end
        n_checks++; if (img_sel !== 5'd0) begin n_fail++; $display("FAIL mid_rst_img_sel: got %0d want 0", img_sel); end
        n_checks++; if (led_rgb !== 3'b000) begin n_fail++; $display("FAIL mid_rst_led: got %b want 000", led_rgb); end
        n_checks++; if (an !== 8'hFE || a_to_g !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_disp: got an %h seg %h want fe ff", an, a_to_g); end
        sys_rst = 1'b0;
        tick();
        do_run(5'd1, RES_TIE27, 4'd2, 0, 1'b1);
    endtask

    task automatic test_scan();
        logic [7:0] exp_an;
        sys_rst = 1'b1; start = 1'b0;
        tick();
        sys_rst = 1'b0;
        for (int d = 0; d < 8; d++) begin
            exp_an = ~(8'b0000_0001 << d);
            for (int j = 0; j < 4; j++) begin
                n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an d%0d c%0d: got %h want %h", d, j, an, exp_an); end
                if (d == 7 && j == 0) begin
                    n_checks++; if (a_to_g !== 8'hFF) begin n_fail++; $display("FAIL dig7_before_run: got %h want ff", a_to_g); end
                end
                tick();
            end
        end
        n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL scan_wrap: got %h want fe", an); end
    endtask

`ifdef TOPS_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        graph = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        run_layer(0, 5, RES_EQ, 1'b0);
        repeat (99) tick();
        n_checks++; if (led_rgb !== 3'b001) begin n_fail++; $display("FAIL tmo_early: got %b want 001", led_rgb); end
        tick();
        n_checks++; if (led_rgb !== 3'b100) begin n_fail++; $display("FAIL tmo_led: got %b want 100", led_rgb); end
        n_checks++; if (lenet_finish !== 1'b0) begin n_fail++; $display("FAIL tmo_finish: got %b want 0", lenet_finish); end
        wait_an(8'hFE);
        n_checks++; if (an !== 8'hFE || a_to_g !== 8'h86) begin n_fail++; $display("FAIL tmo_digit0: got an %h seg %h want fe 86", an, a_to_g); end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_full_run();
        test_done_ignore();
        test_ties();
        test_signed();
        test_midrun_reset();
        test_scan();
`ifdef TOPS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
